uart_tx_frame_fsm: RTL and testbench

//  UART transmit framer: the stage directly downstream of the TX parity generator.

---
 rtl/uart_tx_frame_fsm.sv | 152 +++++++++++++++
 tb/tb_uart_tx_frame_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_fsm.sv
// UART transmit framer: latches a byte plus parity on a valid/ready handshake and
// serialises start, data (LSB first), optional parity and 1-2 stop bits per baud tick.
`timescale 1ns/1ps
module uart_tx_frame_fsm #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_baud_tick,
    input  logic [DATA_W-1:0] i_p_data,
    input  logic              i_data_valid,
    input  logic              i_par_bit,
    input  logic              i_par_en,
    input  logic              i_stop_bits,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSync   = 3'd1,
        StStart  = 3'd2,
        StData   = 3'd3,
        StParity = 3'd4,
        StStop   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_bit_q, par_bit_d;
    logic              par_en_q, par_en_d;
    logic              stop_bits_q, stop_bits_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            stop_bits_q <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            par_bit_q   <= par_bit_d;
            par_en_q    <= par_en_d;
            stop_bits_q <= stop_bits_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        stop_bits_d = stop_bits_q;
        done_d      = 1'b0;

        case (state_q)
            // Ticks are ignored here, so a tick coincident with accept is not consumed.
            StIdle: begin
                if (i_data_valid) begin
                    shreg_d     = i_p_data;
                    par_bit_d   = i_par_bit;
                    par_en_d    = i_par_en;
                    stop_bits_d = i_stop_bits;
                    bit_cnt_d   = '0;
                    stop_cnt_d  = 1'b0;
                    state_d     = StSync;
                end
            end
            StSync: begin
                if (i_baud_tick) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (i_baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (i_baud_tick) begin
                    shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (i_baud_tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (i_baud_tick) begin
                    if (stop_cnt_q == stop_bits_q) begin
                        stop_cnt_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered output moves with the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[0];
            StParity: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign o_tx    = tx_q;
    assign o_done  = done_q;
    assign o_ready = (state_q == StIdle);
    assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// Bench for uart_tx_frame_fsm: expected line levels are queued per accepted frame and
// compared against o_tx at every consumed baud tick; o_done is tracked alongside.
`timescale 1ns/1ps
module tb_uart_tx_frame_fsm;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       valid = 1'b0;
    logic       par_bit = 1'b0;
    logic       par_en = 1'b0;
    logic       stop_bits = 1'b0;
    logic       ready, tx, busy, done;

    uart_tx_frame_fsm #(.DATA_W(8)) dut (
        .i_clk        (clk),
        .i_arst       (arst),
        .i_baud_tick  (tick),
        .i_p_data     (p_data),
        .i_data_valid (valid),
        .i_par_bit    (par_bit),
        .i_par_en     (par_en),
        .i_stop_bits  (stop_bits),
        .o_ready      (ready),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        pb;
        logic        pe;
        logic        sb;
        int          div;
        logic [15:0] line;  // expected levels, first period in bit len-1
        int          len;
    } vec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   tick_div = 1;
    int   done_cnt = 0;
    logic bit_q[$];
    logic exp_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required at %0t", name, $time);
    endtask

    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tick_div <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (cnt == 0);
                cnt  = (cnt + 1) % tick_div;
            end
        end
    end

    initial begin : monitor
        logic e;
        forever begin
            @(negedge clk);
            #1;
            if (arst) begin
                exp_done = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (exp_done || done) begin
                    check("o_done", done, exp_done);
                    if (done) check("ready_with_done", ready, 1);
                end
                exp_done = 1'b0;
                if (tick && busy) begin
                    if (bit_q.size() == 0) begin
                        fail("extra_bit_period");
                    end else begin
                        e = bit_q.pop_front();
                        check("tx_bit", tx, e);
                        if (bit_q.size() == 0) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [15:0] line, input int len);
        bit_q.push_back(1'b1);  // SYNC idle period
        for (int i = len - 1; i >= 0; i--) bit_q.push_back(line[i]);
    endtask

    // Called at a negedge; leaves at a negedge after the accepting posedge.
    task automatic issue(input logic [7:0] d, input logic pb, input logic pe, input logic sb,
                         input logic [15:0] line, input int len, input bit hold);
        int k;
        k = 0;
        while (!ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!ready) fail("ready_timeout");
        p_data = d;
        par_bit = pb;
        par_en = pe;
        stop_bits = sb;
        valid = 1'b1;
        if (ready) push_frame(line, len);
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", ready, 0);
        if (!hold) begin
            valid = 1'b0;
            p_data = 8'($urandom);
            par_bit = 1'($urandom);
            par_en = 1'($urandom);
            stop_bits = 1'($urandom);
        end
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        while (bit_q.size() != 0 && k < 4000) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (bit_q.size() != 0) begin
            fail("frame_timeout");
            bit_q.delete();
        end
        @(negedge clk);
        #2;
    endtask

    vec_t vecs[6];

    initial begin : main
        int d0;
        int k;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 3, 16'b01010010101, 11};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 2, 16'b00000000011, 11};
        vecs[2] = '{8'h81, 1'b0, 1'b1, 1'b0, 1, 16'b01000000101, 11};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3, 16'b011111111111, 12};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1, 16'b00011110011, 11};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 2, 16'b0101010101, 10};

        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        arst = 1'b0;

        // Asynchronous reset while the line is low in the data field.
        tick_div = 4;
        @(negedge clk);
        issue(8'hA5, 1'b0, 1'b1, 1'b0, 16'b01010010101, 11, 0);
        k = 0;
        while (!(bit_q.size() <= 9 && tx == 1'b0) && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (tx !== 1'b0) fail("reach_data_low");
        #1;
        arst = 1'b1;
        bit_q.delete();
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_ready", ready, 1);
        check("arst_done", done, 0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        repeat (8) @(negedge clk);
        check("no_done_after_arst", done_cnt - d0, 0);

        for (int i = 0; i < 6; i++) begin
            tick_div = vecs[i].div;
            d0 = done_cnt;
            issue(vecs[i].data, vecs[i].pb, vecs[i].pe, vecs[i].sb, vecs[i].line,
                  vecs[i].len, 0);
            wait_frame();
            check("done_count", done_cnt - d0, 1);
            check("idle_ready", ready, 1);
            check("idle_tx", tx, 1);
        end

        // Valid with new data during a frame must be ignored.
        tick_div = 4;
        @(negedge clk);
        issue(8'h3C, 1'b0, 1'b1, 1'b1, 16'b000111100011, 12, 0);
        k = 0;
        while (bit_q.size() > 7 && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        @(negedge clk);
        p_data = 8'hFF;
        par_bit = 1'b1;
        par_en = 1'b0;
        stop_bits = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("ready_low_in_frame", ready, 0);
        end
        valid = 1'b0;
        wait_frame();

        // Valid held high: second byte taken in the o_done cycle.
        tick_div = 2;
        @(negedge clk);
        issue(8'h55, 1'b0, 1'b0, 1'b0, 16'b0101010101, 10, 1);
        p_data = 8'h33;
        par_bit = 1'b0;
        par_en = 1'b1;
        stop_bits = 1'b0;
        k = 0;
        while (!ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!ready) fail("b2b_ready_timeout");
        check("accept_in_done_cycle", done, 1);
        push_frame(16'b01100110001, 11);
        @(negedge clk);
        valid = 1'b0;
        check("b2b_busy", busy, 1);
        wait_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
